// File: rtl/coherence_bus_ctrl_if.sv
// Bus bundle between the two dcache/icache pairs, the coherence controller and RAM.
// The controller connects through the slave modport; caches and RAM sit on the master side.
interface coherence_bus_ctrl_if;
    logic [1:0]        dREN, dWEN, ccwrite, cctrans;
    logic [1:0][31:0]  daddr, dstore;
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        dwait, iwait;
    logic [1:0][31:0]  dload, iload;
    logic [1:0]        ccwait, ccinv;
    logic [1:0][31:0]  ccsnoopaddr;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  dREN, dWEN, ccwrite, cctrans, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, iwait, dload, iload, ccwait, ccinv, ccsnoopaddr,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, ccwrite, cctrans, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, iwait, dload, iload, ccwait, ccinv, ccsnoopaddr,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller: arbitrates dcache/icache requests, runs snoops,
// cache-to-cache forwarding, write-invalidates and two-word RAM block transfers.
module coherence_bus_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    coherence_bus_ctrl_if.slave   bus
);
    localparam int          IW         = $clog2(CPUS);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;

    typedef enum logic [3:0] {
        IDLE, SNOOP, FWD0, FWD1, LOAD0, LOAD1, WB0, WB1, INV, IFETCH
    } state_t;

    state_t        state, next_state;
    logic [IW-1:0] req_idx, next_req, rr_ptr, next_rr, oth, pick;
    logic [1:0]    dreq;
    logic          done;

    assign done = (bus.ramstate == RAM_ACCESS);
    assign oth  = ~req_idx;
    assign dreq = bus.dWEN | bus.ccwrite | bus.dREN;

    // Data requests from either core beat instruction fetches; the pointer breaks ties.
    always_comb begin
        pick = rr_ptr;
        if (dreq != 2'b00)
            pick = dreq[rr_ptr] ? rr_ptr : ~rr_ptr;
        else if (bus.iREN != 2'b00)
            pick = bus.iREN[rr_ptr] ? rr_ptr : ~rr_ptr;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            req_idx <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= next_state;
            req_idx <= next_req;
            rr_ptr  <= next_rr;
        end
    end

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no latch is inferred.
        next_state      = state;
        next_req        = req_idx;
        next_rr         = rr_ptr;
        bus.dwait       = 2'b11;
        bus.iwait       = 2'b11;
        bus.ccwait      = 2'b00;
        bus.ccinv       = 2'b00;
        bus.ccsnoopaddr = '0;
        bus.dload       = '0;
        bus.iload       = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = 32'h0;
        bus.ramstore    = 32'h0;

        case (state)
            IDLE: begin
                if (dreq != 2'b00 || bus.iREN != 2'b00) begin
                    next_req = pick;
                    next_rr  = ~pick;
                    if (bus.dWEN[pick])         next_state = WB0;
                    else if (bus.ccwrite[pick]) next_state = INV;
                    else if (bus.dREN[pick])    next_state = SNOOP;
                    else                        next_state = IFETCH;
                end
            end

            WB0, WB1: begin
                bus.ramWEN          = 1'b1;
                bus.ramaddr         = bus.daddr[req_idx];
                bus.ramstore        = bus.dstore[req_idx];
                bus.dwait[req_idx]  = ~done;
                if (done) next_state = (state == WB0) ? WB1 : IDLE;
            end

            SNOOP: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccsnoopaddr[oth] = bus.daddr[req_idx];
                next_state = bus.cctrans[oth] ? FWD0 : LOAD0;
            end

            LOAD0, LOAD1: begin
                bus.ramREN          = 1'b1;
                bus.ramaddr         = bus.daddr[req_idx];
                bus.dload[req_idx]  = bus.ramload;
                bus.dwait[req_idx]  = ~done;
                if (done) next_state = (state == LOAD0) ? LOAD1 : IDLE;
            end

            // The owning cache supplies the block; RAM is updated with the same words.
            FWD0, FWD1: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccsnoopaddr[oth] = bus.daddr[req_idx];
                bus.dload[req_idx]   = bus.dstore[oth];
                bus.ramWEN           = 1'b1;
                bus.ramaddr          = bus.daddr[req_idx];
                bus.ramstore         = bus.dstore[oth];
                bus.dwait[req_idx]   = ~done;
                if (done) next_state = (state == FWD0) ? FWD1 : IDLE;
            end

            INV: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccinv[oth]       = 1'b1;
                bus.ccsnoopaddr[oth] = bus.daddr[req_idx];
                bus.ccinv[req_idx]   = 1'b1;
                next_state           = IDLE;
            end

            IFETCH: begin
                bus.ramREN          = 1'b1;
                bus.ramaddr         = bus.iaddr[req_idx];
                bus.iload[req_idx]  = bus.ramload;
                bus.iwait[req_idx]  = ~done;
                if (done) next_state = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: directed scenarios plus randomized request
// mixes, checked every cycle against a transaction-level model of arbitration and bus phases.
module tb_coherence_bus_ctrl;
    typedef enum {PH_IDLE, PH_SNOOP, PH_LOAD, PH_FWD, PH_WB, PH_INV, PH_IF} phase_e;
    typedef enum {K_WB, K_INV, K_LOAD, K_IF} kind_e;

    typedef struct {
        logic [1:0]       dwait, iwait, ccwait, ccinv;
        logic [1:0][31:0] snp, dload, iload;
        logic             ren, wen;
        logic [31:0]      raddr, rstore;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    coherence_bus_ctrl_if bus ();
    coherence_bus_ctrl #(.CPUS(2)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

    int          total = 0;
    int          bad   = 0;
    logic [1:0]  q_dwen, q_ccw, q_dren, q_iren, q_cct;
    logic [31:0] d_addr [2];
    logic [31:0] d_store[2];
    logic [31:0] i_addr [2];
    logic [31:0] rload;
    int          rr_m;
    int          fixed_wait = -1;
    int          c_g;
    kind_e       k_g;

    task automatic chk(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk(tag, "dwait",   64'(bus.dwait),       64'(e.dwait));
        chk(tag, "iwait",   64'(bus.iwait),       64'(e.iwait));
        chk(tag, "ccwait",  64'(bus.ccwait),      64'(e.ccwait));
        chk(tag, "ccinv",   64'(bus.ccinv),       64'(e.ccinv));
        chk(tag, "snpaddr", 64'(bus.ccsnoopaddr), 64'(e.snp));
        chk(tag, "dload",   64'(bus.dload),       64'(e.dload));
        chk(tag, "iload",   64'(bus.iload),       64'(e.iload));
        chk(tag, "ramREN",  64'(bus.ramREN),      64'(e.ren));
        chk(tag, "ramWEN",  64'(bus.ramWEN),      64'(e.wen));
        chk(tag, "ramaddr", 64'(bus.ramaddr),     64'(e.raddr));
        chk(tag, "ramstore",64'(bus.ramstore),    64'(e.rstore));
    endtask

    // What the bus must show for core r in a given phase of its transaction.
    function automatic exp_t expect_ph(input phase_e ph, input int r, input logic done);
        exp_t e;
        int   o = 1 - r;
        e.dwait = 2'b11; e.iwait = 2'b11; e.ccwait = 2'b00; e.ccinv = 2'b00;
        e.snp = '0; e.dload = '0; e.iload = '0;
        e.ren = 1'b0; e.wen = 1'b0; e.raddr = 32'h0; e.rstore = 32'h0;
        case (ph)
            PH_SNOOP: begin e.ccwait[o] = 1'b1; e.snp[o] = d_addr[r]; end
            PH_LOAD:  begin e.ren = 1'b1; e.raddr = d_addr[r]; e.dload[r] = rload; e.dwait[r] = !done; end
            PH_FWD:   begin
                e.ccwait[o] = 1'b1; e.snp[o] = d_addr[r]; e.dload[r] = d_store[o];
                e.wen = 1'b1; e.raddr = d_addr[r]; e.rstore = d_store[o]; e.dwait[r] = !done;
            end
            PH_WB:    begin e.wen = 1'b1; e.raddr = d_addr[r]; e.rstore = d_store[r]; e.dwait[r] = !done; end
            PH_INV:   begin e.ccwait[o] = 1'b1; e.ccinv[o] = 1'b1; e.snp[o] = d_addr[r]; e.ccinv[r] = 1'b1; end
            PH_IF:    begin e.ren = 1'b1; e.raddr = i_addr[r]; e.iload[r] = rload; e.iwait[r] = !done; end
            default:  ;
        endcase
        return e;
    endfunction

    task automatic drive();
        bus.dWEN = q_dwen; bus.ccwrite = q_ccw; bus.dREN = q_dren; bus.iREN = q_iren; bus.cctrans = q_cct;
        for (int c = 0; c < 2; c++) begin
            bus.daddr[c] = d_addr[c]; bus.dstore[c] = d_store[c]; bus.iaddr[c] = i_addr[c];
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later, well before the rising edge.
    task automatic cyc(input string tag, input phase_e ph, input int r, input logic [1:0] rs);
        rload = $urandom;
        bus.ramstate = rs;
        bus.ramload  = rload;
        drive();
        #1 check_all(tag, expect_ph(ph, r, rs == 2'd2));
        @(negedge CLK);
    endtask

    function automatic logic [1:0] stall_rs();
        logic [1:0] v;
        v = 2'($urandom_range(0, 2));
        return (v == 2'd2) ? 2'd3 : v;
    endfunction

    task automatic word(input string tag, input phase_e ph, input int r);
        int w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
        for (int j = 0; j < w; j++) cyc(tag, ph, r, (fixed_wait >= 0) ? 2'd1 : stall_rs());
        cyc(tag, ph, r, 2'd2);
    endtask

    task automatic txn(input int r, input kind_e k);
        int o = 1 - r;
        case (k)
            K_WB: for (int n = 0; n < 2; n++) begin
                word("wb", PH_WB, r); d_addr[r] += 4; d_store[r] += 4;
            end
            K_INV: cyc("inv", PH_INV, r, 2'($urandom_range(0, 3)));
            K_LOAD: begin
                cyc("snoop", PH_SNOOP, r, 2'($urandom_range(0, 3)));
                for (int n = 0; n < 2; n++) begin
                    if (q_cct[o]) begin word("fwd", PH_FWD, r); d_store[o] += 4; end
                    else          word("load", PH_LOAD, r);
                    d_addr[r] += 4;
                end
            end
            default: begin word("ifetch", PH_IF, r); i_addr[r] += 4; end
        endcase
    endtask

    // Reference arbitration: data before fetch, round-robin between cores, then per-core priority.
    task automatic pick(output int c, output kind_e k);
        logic [1:0] dq;
        dq = q_dwen | q_ccw | q_dren;
        if (dq != 2'b00) c = dq[rr_m] ? rr_m : 1 - rr_m;
        else             c = q_iren[rr_m] ? rr_m : 1 - rr_m;
        if (q_dwen[c])      k = K_WB;
        else if (q_ccw[c])  k = K_INV;
        else if (q_dren[c]) k = K_LOAD;
        else                k = K_IF;
        rr_m = 1 - c;
    endtask

    task automatic clear(input int c, input kind_e k);
        case (k)
            K_WB:    q_dwen[c] = 1'b0;
            K_INV:   q_ccw[c]  = 1'b0;
            K_LOAD:  q_dren[c] = 1'b0;
            default: q_iren[c] = 1'b0;
        endcase
    endtask

    task automatic drain(input string tag);
        int    c;
        kind_e k;
        int    guard = 0;
        while ((q_dwen | q_ccw | q_dren | q_iren) != 2'b00 && guard < 16) begin
            cyc({tag, ".idle"}, PH_IDLE, 0, 2'($urandom_range(0, 3)));
            pick(c, k);
            txn(c, k);
            clear(c, k);
            guard++;
        end
        cyc({tag, ".rest"}, PH_IDLE, 0, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        q_dwen = 0; q_ccw = 0; q_dren = 0; q_iren = 0; q_cct = 0;
        for (int c = 0; c < 2; c++) begin d_addr[c] = 0; d_store[c] = 0; i_addr[c] = 0; end
        rr_m = 0; rload = 0;
        bus.ramstate = 2'd0; bus.ramload = 32'h0;

        // Contention held from reset: core0 WB, core1 miss, core0 fetch.
        nRST = 1'b0;
        q_dwen = 2'b01; q_dren = 2'b10; q_iren = 2'b01;
        d_addr[0] = 32'h300; d_store[0] = 32'h1111_0000; d_addr[1] = 32'h400; i_addr[0] = 32'h1000;
        drive();
        #1 check_all("reset", expect_ph(PH_IDLE, 0, 1'b0));
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;
        drain("contention");

        // Clean miss with two BUSY cycles per word.
        fixed_wait = 2;
        d_addr[0] = 32'h100; q_cct = 2'b00; q_dren = 2'b01;
        drain("clean");

        // Dirty snoop: core1 owns the block and forwards it.
        d_addr[0] = 32'h100; q_cct = 2'b10; d_store[1] = 32'hDEAD_0000; q_dren = 2'b01;
        drain("dirty");
        fixed_wait = -1;

        // Write-invalidate from core1, then simultaneous ccwrite on both cores.
        q_cct = 2'b00; d_addr[1] = 32'h208; q_ccw = 2'b10;
        drain("winv");
        d_addr[0] = 32'h500; d_addr[1] = 32'h600; q_ccw = 2'b11;
        drain("ccw2");

        // Asynchronous reset in the middle of the second load word.
        d_addr[0] = 32'h700; q_dren = 2'b01;
        cyc("r.idle", PH_IDLE, 0, 2'd0);
        pick(c_g, k_g);
        cyc("r.snoop", PH_SNOOP, 0, 2'd0);
        cyc("r.load0", PH_LOAD, 0, 2'd2);
        d_addr[0] += 4;
        rload = $urandom; bus.ramload = rload; bus.ramstate = 2'd1; drive();
        #1 check_all("r.load1", expect_ph(PH_LOAD, 0, 1'b0));
        #1 nRST = 1'b0;
        #1 check_all("r.async", expect_ph(PH_IDLE, 0, 1'b0));
        @(negedge CLK);
        q_dren = 2'b00; rr_m = 0; nRST = 1'b1;
        cyc("r.after", PH_IDLE, 0, 2'd2);
        d_addr[0] = 32'h800; d_addr[1] = 32'h900; q_dren = 2'b11;
        drain("r.rr");

        // Randomized request mixes.
        for (int it = 0; it < 40; it++) begin
            q_dwen = 2'($urandom); q_ccw = 2'($urandom); q_dren = 2'($urandom);
            q_iren = 2'($urandom); q_cct = 2'($urandom);
            for (int c = 0; c < 2; c++) begin
                d_addr[c]  = $urandom & 32'hFFFF_FFFC;
                d_store[c] = $urandom;
                i_addr[c]  = $urandom & 32'hFFFF_FFFC;
            end
            drain($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
